// File: rtl/ibex_data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ibex_data_bus_arbiter
//
// Shares the single CHERIoT data memory port between the ibex core LSU and a
// background requester (TBRE revocation engine). Request muxing and response
// routing are combinational; lock, source FIFO and starvation counter are
// registered on clk_i.
//
// Handshake: a requester raises *_req_i with stable fields and holds both
// until it sees its *_gnt_o; a transfer happens on a cycle where
// data_req_o & data_gnt_i. Each granted transfer is answered by exactly one
// data_rvalid_i, in grant order, and the response is steered to the source
// recorded at grant time.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   core_req_i/gnt_o/rvalid_o          core request handshake + response valid
//   core_we_i/be_i/addr_i/wdata_i/is_cap_i  core request fields
//   bg_req_i/gnt_o/rvalid_o            background handshake + response valid
//   bg_we_i/addr_i/wdata_i/is_cap_i    background fields (always full word)
//   rsp_rdata_o, rsp_err_o             response data/error, broadcast
//   data_req_o/gnt_i/rvalid_i          memory-side handshake
//   data_we_o/be_o/addr_o/wdata_o/is_cap_o  memory-side request fields
//   data_rdata_i, data_err_i           memory-side response
// ---------------------------------------------------------------------------
module ibex_data_bus_arbiter #(
  parameter int unsigned DataWidth      = 33,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_i,
  output logic                 core_gnt_o,
  output logic                 core_rvalid_o,
  input  logic                 core_we_i,
  input  logic [3:0]           core_be_i,
  input  logic [31:0]          core_addr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 core_is_cap_i,
  input  logic                 bg_req_i,
  output logic                 bg_gnt_o,
  output logic                 bg_rvalid_o,
  input  logic                 bg_we_i,
  input  logic [31:0]          bg_addr_i,
  input  logic [DataWidth-1:0] bg_wdata_i,
  input  logic                 bg_is_cap_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_addr_o,
  output logic [DataWidth-1:0] data_wdata_o,
  output logic                 data_is_cap_o,
  input  logic [DataWidth-1:0] data_rdata_i,
  input  logic                 data_err_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned StW  = (StarveLimit == 0) ? 1 : $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] MaxCnt    = CntW'(MaxOutstanding);
  localparam logic [StW-1:0]  StarveMax = StW'(StarveLimit);

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_BG   = 1'b1
  } src_e;

  // Registered state
  logic            r_lock;
  src_e            r_src;
  src_e            r_fifo [MaxOutstanding];
  logic [CntW-1:0] r_cnt;
  logic [StW-1:0]  r_starve;
  logic [CntW-1:0] r_rsp_seen;

  // Combinational
  logic            w_room;
  logic            w_req;
  logic            w_promote;
  src_e            w_sel;
  logic            w_grant;
  logic            w_fifo_empty;
  logic            w_pop;
  src_e            w_fifo_nxt [MaxOutstanding];
  logic [CntW-1:0] w_cnt_nxt;

  // Gating looks only at the registered count, so a response arriving while
  // full frees a slot from the next cycle on, never in the same cycle.
  assign w_room       = (r_cnt < MaxCnt);
  assign w_req        = rst_ni & (core_req_i | bg_req_i) & w_room;
  assign w_promote    = (StarveLimit != 0) && (r_starve == StarveMax);
  assign w_fifo_empty = (r_cnt == '0);
  assign w_grant      = w_req & data_gnt_i;
  assign w_pop        = data_rvalid_i & ~w_fifo_empty;

  // While locked the previously presented source keeps the port so the
  // memory side sees stable fields until it grants.
  always_comb begin
    w_sel = SRC_CORE;
    if (r_lock) begin
      w_sel = r_src;
    end else if (bg_req_i && (!core_req_i || w_promote)) begin
      w_sel = SRC_BG;
    end
  end

  // Request side
  assign data_req_o    = w_req;
  assign core_gnt_o    = w_grant & (w_sel == SRC_CORE);
  assign bg_gnt_o      = w_grant & (w_sel == SRC_BG);
  assign data_we_o     = rst_ni & ((w_sel == SRC_BG) ? bg_we_i : core_we_i);
  assign data_is_cap_o = rst_ni & ((w_sel == SRC_BG) ? bg_is_cap_i : core_is_cap_i);
  assign data_be_o     = !rst_ni ? 4'h0 : ((w_sel == SRC_BG) ? 4'hf : core_be_i);
  assign data_addr_o   = !rst_ni ? 32'h0 : ((w_sel == SRC_BG) ? bg_addr_i : core_addr_i);
  assign data_wdata_o  = !rst_ni ? '0 : ((w_sel == SRC_BG) ? bg_wdata_i : core_wdata_i);

  // Response side: a response with nothing outstanding is dropped.
  assign core_rvalid_o = rst_ni & w_pop & (r_fifo[0] == SRC_CORE);
  assign bg_rvalid_o   = rst_ni & w_pop & (r_fifo[0] == SRC_BG);
  assign rsp_rdata_o   = !rst_ni ? '0 : data_rdata_i;
  assign rsp_err_o     = rst_ni & data_err_i;

  // Source FIFO as a shift register with the head at index 0. Pop shifts
  // first, then a push lands at the post-pop fill level.
  always_comb begin
    w_fifo_nxt = r_fifo;
    w_cnt_nxt  = r_cnt;
    if (w_pop) begin
      for (int i = 0; i < int'(MaxOutstanding) - 1; i++) begin
        w_fifo_nxt[i] = r_fifo[i+1];
      end
      w_fifo_nxt[MaxOutstanding-1] = SRC_CORE;
      w_cnt_nxt = w_cnt_nxt - CntW'(1);
    end
    if (w_grant) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        if (CntW'(i) == w_cnt_nxt) begin
          w_fifo_nxt[i] = w_sel;
        end
      end
      w_cnt_nxt = w_cnt_nxt + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock     <= 1'b0;
      r_src      <= SRC_CORE;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_rsp_seen <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        r_fifo[i] <= SRC_CORE;
      end
    end else begin
      r_fifo <= w_fifo_nxt;
      r_cnt  <= w_cnt_nxt;

      if (w_req && !data_gnt_i) begin
        r_lock <= 1'b1;
        r_src  <= w_sel;
      end else if (w_grant) begin
        r_lock <= 1'b0;
      end

      // Counts core wins while bg is kept waiting; saturation at the limit
      // is what flips selection to bg.
      if (!bg_req_i) begin
        r_starve <= '0;
      end else if (w_grant && (w_sel == SRC_BG)) begin
        r_starve <= '0;
      end else if (w_grant && (w_sel == SRC_CORE) && (r_starve != StarveMax)) begin
        r_starve <= r_starve + StW'(1);
      end

      // Responses seen since reset, saturating; late answers to requests
      // issued before a reset are tolerated during this window.
      if (data_rvalid_i && (r_rsp_seen != MaxCnt)) begin
        r_rsp_seen <= r_rsp_seen + CntW'(1);
      end
    end
  end

  a_no_stray_rvalid : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (data_rvalid_i && w_fifo_empty) |-> (r_rsp_seen < MaxCnt)
  );

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ibex_data_bus_arbiter
//
// Directed scenario tasks followed by a randomized run checked against a
// queue-based reference model of the arbiter. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_ibex_data_bus_arbiter;

  localparam int DW = 33;
  localparam int MO = 2;
  localparam int SL = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT signals
  logic          core_req, core_gnt_o, core_rvalid_o, core_we, core_is_cap;
  logic [3:0]    core_be;
  logic [31:0]   core_addr;
  logic [DW-1:0] core_wdata;
  logic          bg_req, bg_gnt_o, bg_rvalid_o, bg_we, bg_is_cap;
  logic [31:0]   bg_addr;
  logic [DW-1:0] bg_wdata;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          data_req_o, data_gnt, data_rvalid, data_we_o, data_is_cap_o, data_err;
  logic [3:0]    data_be_o;
  logic [31:0]   data_addr_o;
  logic [DW-1:0] data_wdata_o, data_rdata;

  int checks   = 0;
  int failures = 0;

  ibex_data_bus_arbiter #(
    .DataWidth(DW), .MaxOutstanding(MO), .StarveLimit(SL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_we_i(core_we), .core_be_i(core_be), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_is_cap_i(core_is_cap),
    .bg_req_i(bg_req), .bg_gnt_o(bg_gnt_o), .bg_rvalid_o(bg_rvalid_o),
    .bg_we_i(bg_we), .bg_addr_i(bg_addr), .bg_wdata_i(bg_wdata), .bg_is_cap_i(bg_is_cap),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_is_cap_o(data_is_cap_o),
    .data_rdata_i(data_rdata), .data_err_i(data_err)
  );

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_be = 4'h0; core_addr = '0; core_wdata = '0; core_is_cap = 0;
    bg_req = 0; bg_we = 0; bg_addr = '0; bg_wdata = '0; bg_is_cap = 0;
    data_gnt = 0; data_rvalid = 0; data_rdata = '0; data_err = 0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = {1'($urandom_range(0, 1)), 32'($urandom)};
    return d;
  endfunction

  // Scenarios
  task automatic test_reset();
    // Reset held low with every input active: all outputs must stay zero.
    core_req = 1; core_be = 4'h5; core_addr = 32'h1234_5678; core_wdata = rand_data();
    core_we = 1; core_is_cap = 1; bg_req = 1; data_gnt = 1; data_rvalid = 1;
    data_rdata = 33'h1_0F0F_0F0F; data_err = 1;
    repeat (2) cyc();
    #1;
    checks++;
    if ({data_req_o, core_gnt_o, bg_gnt_o, core_rvalid_o, bg_rvalid_o, rsp_err_o,
         data_we_o, data_is_cap_o} !== 8'b0 || rsp_rdata_o !== '0 || data_addr_o !== '0
        || data_be_o !== 4'h0 || data_wdata_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs req=%0b gnt=%0b%0b rv=%0b%0b rdata=%h addr=%h be=%h exp all zero",
               data_req_o, core_gnt_o, bg_gnt_o, core_rvalid_o, bg_rvalid_o, rsp_rdata_o,
               data_addr_o, data_be_o);
    end
    idle();
    cyc();
    rst_n = 1;
    #1;
    checks++;
    if ({data_req_o, core_gnt_o, bg_gnt_o, core_rvalid_o, bg_rvalid_o} !== 5'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=00000",
               {data_req_o, core_gnt_o, bg_gnt_o, core_rvalid_o, bg_rvalid_o});
    end
  endtask

  task automatic test_core_load();
    cyc();
    core_req = 1; core_addr = 32'h2001_0000; core_be = 4'h3; core_is_cap = 1; data_gnt = 1;
    #1;
    checks++;
    if ({data_req_o, core_gnt_o, bg_gnt_o, data_we_o, data_is_cap_o} !== 5'b11001
        || data_addr_o !== 32'h2001_0000 || data_be_o !== 4'h3) begin
      failures++;
      $display("FAIL core_load_req got req/cg/bg/we/cap=%b addr=%h be=%h exp 11001 20010000 3",
               {data_req_o, core_gnt_o, bg_gnt_o, data_we_o, data_is_cap_o}, data_addr_o, data_be_o);
    end
    cyc();
    idle();
    data_rvalid = 1; data_rdata = 33'h1_DEAD_BEEF;
    #1;
    checks++;
    if ({core_rvalid_o, bg_rvalid_o, rsp_err_o} !== 3'b100 || rsp_rdata_o !== 33'h1_DEAD_BEEF) begin
      failures++;
      $display("FAIL core_load_rsp got rv=%b rdata=%h exp 100 1deadbeef",
               {core_rvalid_o, bg_rvalid_o, rsp_err_o}, rsp_rdata_o);
    end
    cyc();
    idle();
  endtask

  task automatic test_starvation();
    logic prev_bg;
    logic exp_bg;
    prev_bg = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      core_req = 1; bg_req = 1; core_be = 4'h3; data_gnt = 1;
      data_rvalid = (i > 0); data_rdata = rand_data();
      #1;
      exp_bg = ((i % 5) == 4);
      checks++;
      if ({core_gnt_o, bg_gnt_o} !== {~exp_bg, exp_bg}) begin
        failures++;
        $display("FAIL starve_grant[%0d] got cg/bg=%b%b exp=%b%b", i, core_gnt_o, bg_gnt_o,
                 ~exp_bg, exp_bg);
      end
      checks++;
      if (data_be_o !== (exp_bg ? 4'hf : 4'h3)) begin
        failures++;
        $display("FAIL starve_be[%0d] got=%h exp=%h", i, data_be_o, exp_bg ? 4'hf : 4'h3);
      end
      if (i > 0) begin
        checks++;
        if ({core_rvalid_o, bg_rvalid_o} !== {~prev_bg, prev_bg}) begin
          failures++;
          $display("FAIL starve_route[%0d] got=%b%b exp=%b%b", i, core_rvalid_o, bg_rvalid_o,
                   ~prev_bg, prev_bg);
        end
      end
      prev_bg = exp_bg;
    end
    cyc();
    idle();
    data_rvalid = 1;
    #1;
    checks++;
    if ({core_rvalid_o, bg_rvalid_o} !== 2'b01) begin
      failures++;
      $display("FAIL starve_last_rsp got=%b%b exp=01", core_rvalid_o, bg_rvalid_o);
    end
    cyc();
    idle();
  endtask

  task automatic test_lock();
    logic [DW-1:0] wd;
    wd = rand_data();
    for (int i = 0; i < 5; i++) begin
      cyc();
      bg_req = (i < 4); bg_addr = 32'h2004_0010; bg_we = 1; bg_wdata = wd;
      core_req = (i >= 1); core_addr = 32'h2001_0100; core_be = 4'h1;
      data_gnt = (i >= 3);
      #1;
      if (i < 4) begin
        checks++;
        if (data_req_o !== 1'b1 || data_addr_o !== 32'h2004_0010 || data_be_o !== 4'hf
            || data_wdata_o !== wd || data_we_o !== 1'b1
            || {core_gnt_o, bg_gnt_o} !== {1'b0, (i == 3)}) begin
          failures++;
          $display("FAIL lock_hold[%0d] got addr=%h be=%h cg/bg=%b%b exp 20040010 f 0%0b",
                   i, data_addr_o, data_be_o, core_gnt_o, bg_gnt_o, (i == 3));
        end
      end else begin
        checks++;
        if ({core_gnt_o, bg_gnt_o} !== 2'b10 || data_addr_o !== 32'h2001_0100) begin
          failures++;
          $display("FAIL lock_core_next got cg/bg=%b%b addr=%h exp 10 20010100",
                   core_gnt_o, bg_gnt_o, data_addr_o);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      idle();
      data_rvalid = 1;
      #1;
      checks++;
      if ({core_rvalid_o, bg_rvalid_o} !== ((i == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL lock_rsp[%0d] got=%b%b exp=%b", i, core_rvalid_o, bg_rvalid_o,
                 (i == 0) ? 2'b01 : 2'b10);
      end
    end
    cyc();
    idle();
  endtask

  task automatic test_max_outstanding();
    // Per-cycle: core_req, rvalid, expected data_req_o, expected core_rvalid_o
    logic [3:0] tbl [7];
    tbl[0] = 4'b1010; tbl[1] = 4'b1010; tbl[2] = 4'b1000; tbl[3] = 4'b1101;
    tbl[4] = 4'b1010; tbl[5] = 4'b0101; tbl[6] = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      cyc();
      idle();
      core_req = tbl[i][3]; data_rvalid = tbl[i][2]; data_gnt = 1; core_be = 4'hc;
      #1;
      checks++;
      if ({data_req_o, core_gnt_o, core_rvalid_o} !== {tbl[i][1], tbl[i][1], tbl[i][0]}) begin
        failures++;
        $display("FAIL max_out[%0d] got req/gnt/rv=%b exp=%b", i,
                 {data_req_o, core_gnt_o, core_rvalid_o}, {tbl[i][1], tbl[i][1], tbl[i][0]});
      end
    end
    cyc();
    idle();
  endtask

  task automatic test_err_order();
    cyc();
    core_req = 1; data_gnt = 1; core_be = 4'hf;
    #1;
    checks++;
    if ({core_gnt_o, bg_gnt_o} !== 2'b10) begin
      failures++;
      $display("FAIL err_core_gnt got=%b%b exp=10", core_gnt_o, bg_gnt_o);
    end
    cyc();
    core_req = 0; bg_req = 1; bg_addr = 32'h2004_0020;
    #1;
    checks++;
    if ({core_gnt_o, bg_gnt_o} !== 2'b01) begin
      failures++;
      $display("FAIL err_bg_gnt got=%b%b exp=01", core_gnt_o, bg_gnt_o);
    end
    cyc();
    idle();
    data_rvalid = 1; data_rdata = 33'h0_1111_2222;
    #1;
    checks++;
    if ({core_rvalid_o, bg_rvalid_o, rsp_err_o} !== 3'b100 || rsp_rdata_o !== 33'h0_1111_2222) begin
      failures++;
      $display("FAIL err_first_rsp got=%b rdata=%h exp=100 011112222",
               {core_rvalid_o, bg_rvalid_o, rsp_err_o}, rsp_rdata_o);
    end
    cyc();
    data_rvalid = 1; data_err = 1;
    #1;
    checks++;
    if ({core_rvalid_o, bg_rvalid_o, rsp_err_o} !== 3'b011) begin
      failures++;
      $display("FAIL err_second_rsp got=%b exp=011", {core_rvalid_o, bg_rvalid_o, rsp_err_o});
    end
    cyc();
    idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    for (int i = 0; i < 2; i++) begin
      cyc();
      core_req = 1; core_addr = 32'h2001_0200; core_be = 4'hf; data_gnt = 1;
    end
    cyc();
    idle();
    rst_n = 0;
    #1;
    checks++;
    if ({data_req_o, core_rvalid_o, bg_rvalid_o} !== 3'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b exp=000", {data_req_o, core_rvalid_o, bg_rvalid_o});
    end
    cyc();
    rst_n = 1;
    cyc();
    data_rvalid = 1; data_rdata = rand_data();
    #1;
    checks++;
    if ({core_rvalid_o, bg_rvalid_o} !== 2'b00) begin
      failures++;
      $display("FAIL reset_stray_rsp got=%b%b exp=00", core_rvalid_o, bg_rvalid_o);
    end
    cyc();
    idle();
    core_req = 1; core_addr = 32'h2001_0300; core_be = 4'hf; data_gnt = 1;
    #1;
    checks++;
    if ({data_req_o, core_gnt_o} !== 2'b11 || data_addr_o !== 32'h2001_0300) begin
      failures++;
      $display("FAIL reset_next_gnt got req/gnt=%b%b addr=%h exp 11 20010300",
               data_req_o, core_gnt_o, data_addr_o);
    end
    cyc();
    idle();
    rd = rand_data();
    data_rvalid = 1; data_rdata = rd;
    #1;
    checks++;
    if ({core_rvalid_o, bg_rvalid_o} !== 2'b10 || rsp_rdata_o !== rd) begin
      failures++;
      $display("FAIL reset_next_rsp got=%b%b rdata=%h exp=10 %h", core_rvalid_o, bg_rvalid_o,
               rsp_rdata_o, rd);
    end
    cyc();
    idle();
  endtask

  // Randomized run against a reference model: outstanding sources kept in a
  // queue in grant order, a committed source while the memory stalls, and a
  // count of core wins while bg waits.
  task automatic test_random();
    logic exp_q[$];
    logic lock_v, lock_bg;
    int   starve;
    logic core_wait, bg_wait;
    logic exp_req, sel_bg, exp_cg, exp_bgg, exp_crv, exp_brv;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [DW-1:0] e_wd;
    logic e_we, e_cap;
    lock_v = 0; lock_bg = 0; starve = 0; core_wait = 0; bg_wait = 0;
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (!core_wait) begin
        core_req = ($urandom_range(0, 2) != 0); core_we = 1'($urandom_range(0, 1));
        core_be = 4'($urandom); core_addr = $urandom; core_wdata = rand_data();
        core_is_cap = 1'($urandom_range(0, 1));
      end
      if (!bg_wait) begin
        bg_req = ($urandom_range(0, 2) != 0); bg_we = 1'($urandom_range(0, 1));
        bg_addr = $urandom; bg_wdata = rand_data(); bg_is_cap = 1'($urandom_range(0, 1));
      end
      data_gnt = ($urandom_range(0, 3) != 0);
      data_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      data_rdata = rand_data(); data_err = 1'($urandom_range(0, 1));
      #1;
      exp_req = (core_req || bg_req) && (exp_q.size() < MO);
      sel_bg  = lock_v ? lock_bg : (bg_req && (!core_req || starve == SL));
      exp_cg  = exp_req && data_gnt && !sel_bg;
      exp_bgg = exp_req && data_gnt && sel_bg;
      exp_crv = data_rvalid && exp_q.size() > 0 && exp_q[0] == 1'b0;
      exp_brv = data_rvalid && exp_q.size() > 0 && exp_q[0] == 1'b1;
      checks++;
      if ({data_req_o, core_gnt_o, bg_gnt_o} !== {exp_req, exp_cg, exp_bgg}) begin
        failures++;
        $display("FAIL rand_req[%0d] got req/cg/bg=%b exp=%b", n,
                 {data_req_o, core_gnt_o, bg_gnt_o}, {exp_req, exp_cg, exp_bgg});
      end
      checks++;
      if ({core_rvalid_o, bg_rvalid_o} !== {exp_crv, exp_brv}
          || rsp_rdata_o !== data_rdata || rsp_err_o !== data_err) begin
        failures++;
        $display("FAIL rand_rsp[%0d] got rv=%b%b rdata=%h err=%b exp rv=%b%b rdata=%h err=%b", n,
                 core_rvalid_o, bg_rvalid_o, rsp_rdata_o, rsp_err_o, exp_crv, exp_brv,
                 data_rdata, data_err);
      end
      if (exp_req) begin
        e_addr = sel_bg ? bg_addr : core_addr;
        e_be   = sel_bg ? 4'hf : core_be;
        e_wd   = sel_bg ? bg_wdata : core_wdata;
        e_we   = sel_bg ? bg_we : core_we;
        e_cap  = sel_bg ? bg_is_cap : core_is_cap;
        checks++;
        if ({data_addr_o, data_be_o, data_wdata_o, data_we_o, data_is_cap_o}
            !== {e_addr, e_be, e_wd, e_we, e_cap}) begin
          failures++;
          $display("FAIL rand_fields[%0d] got addr=%h be=%h we=%b cap=%b exp addr=%h be=%h we=%b cap=%b",
                   n, data_addr_o, data_be_o, data_we_o, data_is_cap_o, e_addr, e_be, e_we, e_cap);
        end
      end
      // Model update for the coming edge
      if (data_rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_cg || exp_bgg) exp_q.push_back(sel_bg);
      if (exp_req && !data_gnt) begin
        lock_v = 1; lock_bg = sel_bg;
      end else if (exp_req && data_gnt) begin
        lock_v = 0;
      end
      if (!bg_req) starve = 0;
      else if (exp_bgg) starve = 0;
      else if (exp_cg && starve < SL) starve++;
      core_wait = core_req && !exp_cg;
      bg_wait   = bg_req && !exp_bgg;
    end
    // Drain the outstanding responses
    for (int k = 0; k < MO + 1; k++) begin
      cyc();
      core_req = 0; bg_req = 0; data_gnt = 0;
      data_rvalid = (exp_q.size() > 0);
      #1;
      exp_crv = data_rvalid && exp_q[0] == 1'b0;
      exp_brv = data_rvalid && exp_q[0] == 1'b1;
      checks++;
      if ({core_rvalid_o, bg_rvalid_o} !== {exp_crv, exp_brv}) begin
        failures++;
        $display("FAIL rand_drain[%0d] got=%b%b exp=%b%b", k, core_rvalid_o, bg_rvalid_o,
                 exp_crv, exp_brv);
      end
      if (data_rvalid) void'(exp_q.pop_front());
    end
    cyc();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1;
    #1;
    rst_n = 0;
    test_reset();
    test_core_load();
    test_starvation();
    test_lock();
    test_max_outstanding();
    test_err_order();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
